frame_trimmer: RTL and testbench

FRAME_TRIMMER -- requirements
Module: frame_trimmer

---
 rtl/frame_trimmer.sv | 195 +++++++++++++++++++
 tb/tb_frame_trimmer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_trimmer.sv
// ---------------------------------------------------------------------------
// frame_trimmer
//   Crops a raster video stream (AXI4-Stream style) by CROP_LEFT/RIGHT columns
//   and CROP_TOP/BOTTOM lines. Every input beat is consumed. Only beats inside
//   the kept window are registered into a single output stage, which adds
//   1 cycle of latency. Output tuser marks the first kept pixel of a frame and
//   output tlast marks the last kept pixel of each line.
//
//   Optional feature macro: FRAME_TRIMMER_GEOM_CHECK_EN
//     When defined, trim_err_o is a sticky flag for line/frame geometry
//     errors: tlast at the wrong x, a missing tlast, or a misplaced tuser.
//     When undefined, trim_err_o is tied to 0.
//
// Ports
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   video_i_*              input stream  (tdata/tvalid/tready/tuser=SOF/
//                          tlast=EOL/tid/tdest)
//   video_o_*              output stream (adds tkeep/tstrb, both all-ones)
//   trim_err_o             sticky geometry error
// ---------------------------------------------------------------------------
module frame_trimmer #(
    parameter int PX_WIDTH        = 10,
    parameter int CHANNELS_AMOUNT = 3,
    parameter int FRAME_RES_X     = 1924,
    parameter int FRAME_RES_Y     = 1084,
    parameter int CROP_LEFT       = 2,
    parameter int CROP_RIGHT      = 2,
    parameter int CROP_TOP        = 2,
    parameter int CROP_BOTTOM     = 2,
    parameter int ID_WIDTH        = 4,
    parameter int DEST_WIDTH      = 4,
    localparam int TDATA_WIDTH    = ((PX_WIDTH * CHANNELS_AMOUNT + 7) / 8) * 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,

    input  logic [TDATA_WIDTH-1:0]   video_i_tdata,
    input  logic                     video_i_tvalid,
    output logic                     video_i_tready,
    input  logic                     video_i_tuser,
    input  logic                     video_i_tlast,
    input  logic [ID_WIDTH-1:0]      video_i_tid,
    input  logic [DEST_WIDTH-1:0]    video_i_tdest,

    output logic [TDATA_WIDTH-1:0]   video_o_tdata,
    output logic                     video_o_tvalid,
    input  logic                     video_o_tready,
    output logic                     video_o_tuser,
    output logic                     video_o_tlast,
    output logic [TDATA_WIDTH/8-1:0] video_o_tkeep,
    output logic [TDATA_WIDTH/8-1:0] video_o_tstrb,
    output logic [ID_WIDTH-1:0]      video_o_tid,
    output logic [DEST_WIDTH-1:0]    video_o_tdest,

    output logic                     trim_err_o
);

    localparam int PAY_W = PX_WIDTH * CHANNELS_AMOUNT;
    // Counter widths can hold FRAME_RES_* itself so the exclusive upper
    // window bound is representable even with zero right/bottom crop.
    localparam int XW = $clog2(FRAME_RES_X + 1);
    localparam int YW = $clog2(FRAME_RES_Y + 1);

    localparam logic [XW-1:0] X_LAST = XW'(FRAME_RES_X - 1);
    localparam logic [XW-1:0] X_LO   = XW'(CROP_LEFT);
    localparam logic [XW-1:0] X_HI   = XW'(FRAME_RES_X - CROP_RIGHT);
    localparam logic [XW-1:0] X_EOL  = XW'(FRAME_RES_X - CROP_RIGHT - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_RES_Y - 1);
    localparam logic [YW-1:0] Y_LO   = YW'(CROP_TOP);
    localparam logic [YW-1:0] Y_HI   = YW'(FRAME_RES_Y - CROP_BOTTOM);

    logic [XW-1:0]          r_x_cnt;
    logic [YW-1:0]          r_y_cnt;
    logic                   r_synced;
    logic                   r_tvalid;
    logic [TDATA_WIDTH-1:0] r_tdata;
    logic                   r_tuser;
    logic                   r_tlast;
    logic [ID_WIDTH-1:0]    r_tid;
    logic [DEST_WIDTH-1:0]  r_tdest;

    logic                   w_in_rdy;
    logic                   w_acc;
    logic [XW-1:0]          w_cur_x;
    logic [YW-1:0]          w_cur_y;
    logic [XW-1:0]          w_nxt_x;
    logic [YW-1:0]          w_nxt_y;
    logic                   w_in_x;
    logic                   w_in_y;
    logic                   w_keep;
    logic [TDATA_WIDTH-1:0] w_tdata_m;

    // Discarded beats still wait for a free output slot, so the upstream
    // handshake is identical whether or not the beat is kept.
    assign w_in_rdy = !r_tvalid || video_o_tready;
    assign w_acc    = video_i_tvalid && w_in_rdy;

    // tuser forces this beat to (0,0) whatever the counters say.
    assign w_cur_x = video_i_tuser ? '0 : r_x_cnt;
    assign w_cur_y = video_i_tuser ? '0 : r_y_cnt;

    // Lower-bound compare is skipped for a zero crop to avoid a trivially
    // true unsigned compare.
    assign w_in_x = ((CROP_LEFT == 0) || (w_cur_x >= X_LO)) && (w_cur_x < X_HI);
    assign w_in_y = ((CROP_TOP  == 0) || (w_cur_y >= Y_LO)) && (w_cur_y < Y_HI);
    // Nothing is kept until the first tuser has aligned the counters.
    assign w_keep = (r_synced || video_i_tuser) && w_in_x && w_in_y;

    // Next position. A line that runs past FRAME_RES_X-1 without tlast is
    // treated as ended so the counters stay in range.
    always_comb begin
        w_nxt_x = w_cur_x + 1'b1;
        w_nxt_y = w_cur_y;
        if (video_i_tlast || (w_cur_x == X_LAST)) begin
            w_nxt_x = '0;
            w_nxt_y = (w_cur_y == Y_LAST) ? '0 : w_cur_y + 1'b1;
        end
    end

    // Padding bits above the pixel payload are forced to zero.
    always_comb begin
        w_tdata_m = '0;
        for (int b = 0; b < TDATA_WIDTH; b++)
            w_tdata_m[b] = (b < PAY_W) ? video_i_tdata[b] : 1'b0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_x_cnt  <= '0;
            r_y_cnt  <= '0;
            r_synced <= 1'b0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tuser  <= 1'b0;
            r_tlast  <= 1'b0;
            r_tid    <= '0;
            r_tdest  <= '0;
        end else begin
            if (w_acc) begin
                r_x_cnt <= w_nxt_x;
                r_y_cnt <= w_nxt_y;
                if (video_i_tuser)
                    r_synced <= 1'b1;
            end
            // Output stage only changes when it is empty or being drained,
            // which keeps payload stable under backpressure.
            if (w_in_rdy) begin
                r_tvalid <= w_acc && w_keep;
                if (w_acc && w_keep) begin
                    r_tdata <= w_tdata_m;
                    r_tuser <= (w_cur_x == X_LO) && (w_cur_y == Y_LO);
                    r_tlast <= (w_cur_x == X_EOL);
                    r_tid   <= video_i_tid;
                    r_tdest <= video_i_tdest;
                end
            end
        end
    end

    assign video_i_tready = w_in_rdy;
    assign video_o_tvalid = r_tvalid;
    assign video_o_tdata  = r_tdata;
    assign video_o_tuser  = r_tuser;
    assign video_o_tlast  = r_tlast;
    assign video_o_tid    = r_tid;
    assign video_o_tdest  = r_tdest;
    assign video_o_tkeep  = '1;
    assign video_o_tstrb  = '1;

`ifdef FRAME_TRIMMER_GEOM_CHECK_EN
    logic r_err;
    logic w_err_evt;

    // Line-length checks only make sense once position is aligned; the
    // tuser-position check applies to every frame after the first tuser.
    assign w_err_evt = w_acc && (
                           ((r_synced || video_i_tuser) &&
                            ((video_i_tlast && (w_cur_x != X_LAST)) ||
                             (!video_i_tlast && (w_cur_x == X_LAST)))) ||
                           (video_i_tuser && r_synced &&
                            ((r_x_cnt != '0) || (r_y_cnt != '0))));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_err <= 1'b0;
        else if (w_err_evt)
            r_err <= 1'b1;
    end

    assign trim_err_o = r_err;
`else
    assign trim_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_frame_trimmer.sv
// Directed bench for frame_trimmer.
//   u_dut_a: 6x5 frame, crops L2 R1 T1 B2 -> kept window x 2..4, y 1..2.
//   u_dut_b: 1x3 frame, no crop -> pass-through, tuser+tlast coincident.
module tb_frame_trimmer;

    localparam int TDW = 16;   // 5 bits x 3 channels -> 15, padded to 16
    localparam int RX  = 6;
`ifdef FRAME_TRIMMER_GEOM_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int kcnt  = 0;

    // DUT A stream
    logic [TDW-1:0] a_tdata = '0;
    logic           a_tvalid = 1'b0, a_tready, a_tuser = 1'b0, a_tlast = 1'b0;
    logic [3:0]     a_tid = '0, a_tdest = '0;
    logic [TDW-1:0] a_o_tdata;
    logic           a_o_tvalid, a_o_tready = 1'b1, a_o_tuser, a_o_tlast;
    logic [1:0]     a_o_tkeep, a_o_tstrb;
    logic [3:0]     a_o_tid, a_o_tdest;
    logic           a_err;

    // DUT B stream
    logic [TDW-1:0] b_tdata = '0;
    logic           b_tvalid = 1'b0, b_tready, b_tuser = 1'b0, b_tlast = 1'b0;
    logic [3:0]     b_tid = '0, b_tdest = '0;
    logic [TDW-1:0] b_o_tdata;
    logic           b_o_tvalid, b_o_tready = 1'b1, b_o_tuser, b_o_tlast;
    logic [1:0]     b_o_tkeep, b_o_tstrb;
    logic [3:0]     b_o_tid, b_o_tdest;
    logic           b_err;

    frame_trimmer #(
        .PX_WIDTH(5), .CHANNELS_AMOUNT(3), .FRAME_RES_X(6), .FRAME_RES_Y(5),
        .CROP_LEFT(2), .CROP_RIGHT(1), .CROP_TOP(1), .CROP_BOTTOM(2),
        .ID_WIDTH(4), .DEST_WIDTH(4)
    ) u_dut_a (
        .clk_i(clk), .rstn_i(rstn_i),
        .video_i_tdata(a_tdata), .video_i_tvalid(a_tvalid), .video_i_tready(a_tready),
        .video_i_tuser(a_tuser), .video_i_tlast(a_tlast), .video_i_tid(a_tid),
        .video_i_tdest(a_tdest),
        .video_o_tdata(a_o_tdata), .video_o_tvalid(a_o_tvalid), .video_o_tready(a_o_tready),
        .video_o_tuser(a_o_tuser), .video_o_tlast(a_o_tlast), .video_o_tkeep(a_o_tkeep),
        .video_o_tstrb(a_o_tstrb), .video_o_tid(a_o_tid), .video_o_tdest(a_o_tdest),
        .trim_err_o(a_err)
    );

    frame_trimmer #(
        .PX_WIDTH(5), .CHANNELS_AMOUNT(3), .FRAME_RES_X(1), .FRAME_RES_Y(3),
        .CROP_LEFT(0), .CROP_RIGHT(0), .CROP_TOP(0), .CROP_BOTTOM(0),
        .ID_WIDTH(4), .DEST_WIDTH(4)
    ) u_dut_b (
        .clk_i(clk), .rstn_i(rstn_i),
        .video_i_tdata(b_tdata), .video_i_tvalid(b_tvalid), .video_i_tready(b_tready),
        .video_i_tuser(b_tuser), .video_i_tlast(b_tlast), .video_i_tid(b_tid),
        .video_i_tdest(b_tdest),
        .video_o_tdata(b_o_tdata), .video_o_tvalid(b_o_tvalid), .video_o_tready(b_o_tready),
        .video_o_tuser(b_o_tuser), .video_o_tlast(b_o_tlast), .video_o_tkeep(b_o_tkeep),
        .video_o_tstrb(b_o_tstrb), .video_o_tid(b_o_tid), .video_o_tdest(b_o_tdest),
        .trim_err_o(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Ramp pixel with padding bit 15 set; the DUT must clear it.
    function automatic logic [TDW-1:0] dat(input int x, input int y);
        return 16'hA400 | 16'(y * 16 + x);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int y, input logic u, input logic l);
        a_tvalid = 1'b1;
        a_tuser  = u;
        a_tlast  = l;
        a_tdata  = dat(x, y);
        a_tid    = 4'(x);
        a_tdest  = 4'(y);
    endtask

    // Expected output for a beat at source (x,y) one cycle after acceptance.
    task automatic chk_out(input int x, input int y);
        logic k;
        k = (x >= 2) && (x < 5) && (y >= 1) && (y < 3);
        chk("a_vld", a_o_tvalid, k);
        if (a_o_tvalid) kcnt++;
        if (k) begin
            chk("a_data",  a_o_tdata, dat(x, y) & 16'h7FFF);
            chk("a_tuser", a_o_tuser, (x == 2) && (y == 1));
            chk("a_tlast", a_o_tlast, x == 4);
            chk("a_tid",   a_o_tid, 4'(x));
            chk("a_tdest", a_o_tdest, 4'(y));
        end
    endtask

    task automatic line_run(input int y, input int x0, input int x1, input logic sof);
        for (int x = x0; x <= x1; x++) begin
            drive(x, y, sof && (x == 0) && (y == 0), x == RX - 1);
            tick();
            chk_out(x, y);
        end
        a_tvalid = 1'b0;
    endtask

    task automatic frame_run();
        kcnt = 0;
        for (int y = 0; y < 5; y++) line_run(y, 0, RX - 1, 1'b1);
        chk("a_frame_beats", kcnt, 6);
    endtask

    // Beats with no tuser while unaligned: nothing may come out.
    task automatic blind(input int x0, input int y0, input int n);
        int x, y;
        x = x0;
        y = y0;
        for (int i = 0; i < n; i++) begin
            drive(x, y, 1'b0, x == RX - 1);
            tick();
            chk("a_nosync_vld", a_o_tvalid, 1'b0);
            x++;
            if (x == RX) begin x = 0; y = (y + 1) % 5; end
        end
        a_tvalid = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_vld",   a_o_tvalid, 1'b0);
        chk("rst_tuser", a_o_tuser, 1'b0);
        chk("rst_tlast", a_o_tlast, 1'b0);
        chk("rst_tdata", a_o_tdata, 16'h0);
        chk("rst_tready", a_tready, 1'b1);
        chk("rst_err",   a_err, 1'b0);
        chk("rst_tkeep", {a_o_tkeep, a_o_tstrb}, 4'hF);
        tick();
        tick();
        rstn_i = 1'b1;
        tick();
        chk("post_rst_tready", a_tready, 1'b1);

        // No output before the first tuser
        blind(0, 1, 8);

        // Two back-to-back full frames
        frame_run();
        frame_run();

        // Backpressure: output held, input stalled
        line_run(0, 0, RX - 1, 1'b1);
        line_run(1, 0, 2, 1'b0);
        a_o_tready = 1'b0;
        drive(3, 1, 1'b0, 1'b0);
        #1;
        chk("stall_tready", a_tready, 1'b0);
        tick();
        chk("stall_vld1",  a_o_tvalid, 1'b1);
        chk("stall_data1", a_o_tdata, dat(2, 1) & 16'h7FFF);
        tick();
        chk("stall_data2",  a_o_tdata, dat(2, 1) & 16'h7FFF);
        chk("stall_tuser2", a_o_tuser, 1'b1);
        a_o_tready = 1'b1;
        #1;
        chk("unstall_tready", a_tready, 1'b1);
        tick();
        chk_out(3, 1);
        line_run(1, 4, RX - 1, 1'b0);
        for (int y = 2; y < 5; y++) line_run(y, 0, RX - 1, 1'b0);

        // Reset mid-frame with a kept beat in the output register
        line_run(0, 0, RX - 1, 1'b1);
        line_run(1, 0, RX - 1, 1'b0);
        line_run(2, 0, 2, 1'b0);
        chk("pre_rst_vld", a_o_tvalid, 1'b1);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("async_rst_vld",   a_o_tvalid, 1'b0);
        chk("async_rst_tdata", a_o_tdata, 16'h0);
        chk("async_rst_tuser", a_o_tuser, 1'b0);
        chk("async_rst_tready", a_tready, 1'b1);
        tick();
        rstn_i = 1'b1;
        blind(3, 2, 15);
        frame_run();
        chk("clean_err", a_err, 1'b0);

        // Early tlast on a line
        for (int x = 0; x < 4; x++) begin
            drive(x, 0, x == 0, x == 3);
            tick();
        end
        a_tvalid = 1'b0;
        tick();
        chk("geom_err_set", a_err, ERR_EN);
        drive(0, 1, 1'b0, 1'b0);
        tick();
        drive(1, 1, 1'b0, 1'b0);
        tick();
        a_tvalid = 1'b0;
        tick();
        chk("geom_err_sticky", a_err, ERR_EN);
        rstn_i = 1'b0;
        #1;
        chk("geom_err_clr", a_err, 1'b0);
        tick();
        rstn_i = 1'b1;
        tick();

        // 1-pixel-wide pass-through; frame 1 has no tuser so output tuser
        // relies on y wrapping back to 0.
        for (int f = 0; f < 3; f++) begin
            for (int y = 0; y < 3; y++) begin
                b_tvalid = 1'b1;
                b_tuser  = (y == 0) && (f != 1);
                b_tlast  = 1'b1;
                b_tdata  = 16'h8000 | 16'(f * 16 + y);
                b_tid    = 4'(y);
                b_tdest  = 4'(f);
                if (f == 0 && y == 0) begin
                    #1;
                    chk("b_latency_pre", b_o_tvalid, 1'b0);
                end
                tick();
                chk("b_vld",   b_o_tvalid, 1'b1);
                chk("b_data",  b_o_tdata, 16'(f * 16 + y));
                chk("b_tuser", b_o_tuser, y == 0);
                chk("b_tlast", b_o_tlast, 1'b1);
                chk("b_tid",   {b_o_tdest, b_o_tid}, {4'(f), 4'(y)});
            end
        end
        b_tvalid = 1'b0;
        tick();
        chk("b_idle_vld", b_o_tvalid, 1'b0);
        chk("b_err", b_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
